fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Shares the single write port of the byte FIFO between N_REQ producers using round-robin arbitration. Adds watermark hysteresis on top of the arbitration: writes are granted while the fill level is below HI_MARK, then blocked until the level drains to LO_MARK or below. Sits between the producer blocks and the FIFO write side, and replaces per-producer write sequencers.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 8, FIFO data width
CNT_W, 4, width of fifo_words
HI_MARK, 5, fill level at or above which writes stop
LO_MARK, 2, fill level at or below which writes resume (must be < HI_MARK)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
req  in  N_REQ  per-requester write request; held with data until granted
req_data  in  N_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
gnt  out  N_REQ  one-hot combinational grant; req[i]&gnt[i] at a posedge is one transfer
fifo_words  in  CNT_W  current FIFO occupancy
wr_en  out  1  registered FIFO write strobe
fifo_data  out  DATA_W  registered FIFO write data
throttled  out  1  registered; 1 while in HOLD

Behaviour:
- Reset (rst_n=0 at posedge): state=FILL, wr_en=0, fifo_data=0, throttled=0, last-grant pointer=N_REQ-1 (so req[0] has first priority). gnt=0 during reset.
- States:
  - FILL: go to HOLD when fifo_words >= HI_MARK.
  - HOLD: go to FILL when fifo_words <= LO_MARK.
  - Otherwise stay.
- Grant enable: grant_ok = (state==FILL) && (fifo_words < HI_MARK). gnt is forced to 0 when grant_ok=0, including the cycle in which FILL->HOLD is decided.
- Round-robin: search req starting at pointer+1 modulo N_REQ; the first set bit wins. The pointer updates to the winner only on a grant. With a single requester, that requester is granted every cycle.
- Latency: a grant at edge t drives wr_en=1 and fifo_data=req_data[winner] after edge t, i.e. visible in cycle t+1. With no grant, wr_en=0 and fifo_data holds its last value.
- Throughput: at most 1 write per cycle. Back-to-back grants are allowed.
- fifo_words lags by one in-flight write. FIFO depth must be >= HI_MARK+2. No overflow is possible under this rule.
- Requester contract: req and data are stable until gnt. After a grant, the requester may deassert or present the next word in the following cycle.
- Mid-operation reset: wr_en is cleared at that edge. A pending grant is discarded (no partial write). The pointer returns to N_REQ-1.
- fifo_words == HI_MARK in HOLD and == LO_MARK in FILL: no transition.

Optional Feature:
STALL_CNT_EN:
- Defined: adds output stall_cycles [15:0], a saturating count of cycles with state==HOLD and |req. It resets to 0 and sticks at 16'hFFFF.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_ctrl_pkg: state encoding (FILL=1'b0, HOLD=1'b1), default HI_MARK/LO_MARK constants.
- Sub-module rr_arbiter (N parameter): inputs req, enable, pointer; outputs one-hot gnt and winner index. Purely combinational. The pointer register lives in the parent.

Test Plan:
1. Reset, req=2'b01, data0=8'hAA, fifo_words=0 -> gnt=01 each cycle; wr_en=1 from the cycle after first gnt; fifo_data=8'hAA.
2. req=2'b11, data0=8'h11, data1=8'h22, fifo_words=0 -> grants alternate 01,10,01,...; fifo_data sequence 11,22,11,...
3. Ramp fifo_words 0..5 -> gnt=0 in the cycle fifo_words=5; throttled=1 next cycle; no wr_en while fifo_words is 4 or 3 during drain; resume (gnt!=0) one cycle after fifo_words=2.
4. In HOLD with fifo_words=3 held for 10 cycles -> gnt=0, wr_en=0 for all 10 cycles. With STALL_CNT_EN and req=01 -> stall_cycles=10.
5. Assert rst_n=0 for 1 cycle mid-burst with req=11 -> wr_en=0, throttled=0 next cycle; first post-reset grant goes to req[0].
6. req deasserted while in FILL -> wr_en=0, fifo_data retains its last value, pointer unchanged.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-side controller: fill/hold state
// encoding and the default watermark levels.
package fifo_ctrl_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fill_state_e;

    localparam int DEF_HI_MARK = 5;
    localparam int DEF_LO_MARK = 2;
    localparam int STALL_W     = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the pointer,
// wraps modulo N, and the first asserted request wins.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic             enable,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] winner
);

    localparam int SUM_W = IDX_W + 2;

    logic [SUM_W-1:0] sum  [N];
    logic [IDX_W-1:0] cand [N];
    logic             found;

    // cand[k] is the k-th index visited; pointer < N so one subtraction wraps it
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign sum[gi]  = SUM_W'(pointer) + SUM_W'(gi + 1);
            assign cand[gi] = (sum[gi] >= SUM_W'(N)) ? IDX_W'(sum[gi] - SUM_W'(N))
                                                     : IDX_W'(sum[gi]);
        end
    endgenerate

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (enable && !found && req[cand[k]]) begin
                found            = 1'b1;
                winner           = cand[k];
                gnt[cand[k]]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of the FIFO write port with HI/LO watermark hysteresis.
// Optional `STALL_CNT_EN adds a saturating stall_cycles counter output.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 4,
    parameter int HI_MARK = DEF_HI_MARK,
    parameter int LO_MARK = DEF_LO_MARK
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    input  logic [CNT_W-1:0]        fifo_words,
    output logic                    wr_en,
    output logic [DATA_W-1:0]       fifo_data,
    output logic                    throttled
`ifdef STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]      stall_cycles
`endif
);

    localparam int               IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] HI_LVL = CNT_W'(HI_MARK);
    localparam logic [CNT_W-1:0] LO_LVL = CNT_W'(LO_MARK);

    fill_state_e       state_reg;
    logic [IDX_W-1:0]  ptr_reg;
    logic [IDX_W-1:0]  winner;
    logic              at_hi;
    logic              at_lo;
    logic              grant_ok;
    logic [DATA_W-1:0] data_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_data
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign at_hi = (fifo_words >= HI_LVL);
    assign at_lo = (fifo_words <= LO_LVL);

    // Blocking in the FILL->HOLD decision cycle keeps the in-flight write count at one
    assign grant_ok = rst_n && (state_reg == FILL) && !at_hi;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .enable  (grant_ok),
        .pointer (ptr_reg),
        .gnt     (gnt),
        .winner  (winner)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= FILL;
            throttled <= 1'b0;
            wr_en     <= 1'b0;
            fifo_data <= '0;
            ptr_reg   <= IDX_W'(N_REQ - 1);
        end else begin
            case (state_reg)
                FILL: begin
                    if (at_hi) begin
                        state_reg <= HOLD;
                        throttled <= 1'b1;
                    end
                end
                HOLD: begin
                    if (at_lo) begin
                        state_reg <= FILL;
                        throttled <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= FILL;
                    throttled <= 1'b0;
                end
            endcase

            wr_en <= |gnt;
            if (|gnt) begin
                fifo_data <= data_arr[winner];
                ptr_reg   <= winner;
            end
        end
    end

`ifdef STALL_CNT_EN
    logic [STALL_W-1:0] stall_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_reg <= '0;
        end else if ((state_reg == HOLD) && (|req) && (stall_reg != {STALL_W{1'b1}})) begin
            stall_reg <= stall_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_reg;
`endif

endmodule
